// File: rtl/sr_pkg.sv
// Shared definitions for the shift-register and frame-receiver blocks.
// State codes, default register width and the receiver state type.
package sr_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int SR_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } rx_state_t;

endpackage

// File: rtl/sipo_frame_rx_if.sv
// Serial-in / parallel-out bundle of the frame receiver.
// The master drives the serial line and watches the word and strobes.
interface sipo_frame_rx_if #(
    parameter int WIDTH = 4
);

    logic             sin;
    logic [WIDTH-1:0] dout;
    logic             dvalid;
    logic             ferr;
    logic             perr;
    logic             busy;

    modport master (
        output sin,
        input  dout,
        input  dvalid,
        input  ferr,
        input  perr,
        input  busy
    );

    modport slave (
        input  sin,
        output dout,
        output dvalid,
        output ferr,
        output perr,
        output busy
    );

endinterface

// File: rtl/sipo_bit_counter.sv
// Data-bit counter of the frame receiver: clearable up-counter
// flagging the last data bit (cnt == WIDTH-1).
module sipo_bit_counter
    import sr_pkg::*;
#(
    parameter  int WIDTH = SR_WIDTH_DEF,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CW-1:0] r_cnt;

    // Count data bits; clear wins over enable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start, WIDTH data bits LSB first, [parity], stop.
// Optional even-parity check is built when PARITY_CHECK_EN is defined.
module sipo_frame_rx
    import sr_pkg::*;
#(
    parameter int   WIDTH     = SR_WIDTH_DEF,
    parameter logic START_LVL = 1'b1
) (
    input  logic             c,
    input  logic             r,
    sipo_frame_rx_if.slave   bus
);

    rx_state_t        r_state;
    rx_state_t        w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_dout;
    logic             r_dvalid;
    logic             w_dvalid;
    logic             r_ferr;
    logic             w_ferr;
    logic             w_clr;
    logic             w_en;
    logic             w_tc;
`ifdef PARITY_CHECK_EN
    logic             r_par;
    logic             w_par;
    logic             r_perr;
    logic             w_perr;
`endif

    sipo_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .i_clk (c),
        .i_rst (r),
        .i_clr (w_clr),
        .i_en  (w_en),
        .o_tc  (w_tc)
    );

    // State register plus the datapath and registered strobes.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_dout   <= '0;
            r_dvalid <= 1'b0;
            r_ferr   <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_par    <= 1'b0;
            r_perr   <= 1'b0;
`endif
        end else begin
            r_state  <= w_next;
            r_shreg  <= w_shreg;
            r_dout   <= w_dout;
            r_dvalid <= w_dvalid;
            r_ferr   <= w_ferr;
`ifdef PARITY_CHECK_EN
            r_par    <= w_par;
            r_perr   <= w_perr;
`endif
        end
    end

    // Next state, shift/capture data and strobe decisions.
    always_comb begin
        w_next   = r_state;
        w_shreg  = r_shreg;
        w_dout   = r_dout;
        w_dvalid = 1'b0;
        w_ferr   = 1'b0;
        w_clr    = 1'b0;
        w_en     = 1'b0;
`ifdef PARITY_CHECK_EN
        w_par    = r_par;
        w_perr   = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (bus.sin == START_LVL) begin
                    w_next = S_DATA;
                    w_clr  = 1'b1;
                end
            end
            S_DATA: begin
                w_shreg = {bus.sin, r_shreg[WIDTH-1:1]};
                w_en    = 1'b1;
                if (w_tc) begin
`ifdef PARITY_CHECK_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            S_PARITY: begin
                w_par  = bus.sin;
                w_next = S_STOP;
            end
`endif
            S_STOP: begin
                w_next = S_IDLE;
                if (bus.sin == ~START_LVL) begin
                    w_dout   = r_shreg;
                    w_dvalid = 1'b1;
`ifdef PARITY_CHECK_EN
                    w_perr   = (^r_shreg) ^ r_par;
`endif
                end else begin
                    w_ferr = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.dout   = r_dout;
    assign bus.dvalid = r_dvalid;
    assign bus.ferr   = r_ferr;
    assign bus.busy   = (r_state != S_IDLE);
`ifdef PARITY_CHECK_EN
    assign bus.perr   = r_perr;
`else
    assign bus.perr   = 1'b0;
`endif

endmodule
